// File: rtl/neuron_accumulator_bank.sv
// Bank of N_NEURONS signed MAC accumulators with a one-per-cycle ReLU/scale/saturate drain.
// Lanes own the multiply-accumulate; the top owns layer tracking and the drain pointer.

module neuron_acc_lane #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     acc_en,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     sat
);
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic        [ACC_W:0]      sum;
  logic                       ovf;

  assign prod     = x * w;
  assign prod_ext = ACC_W'(prod);
  // One guard bit: overflow when the two top bits of the sum disagree.
  assign sum      = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  assign ovf      = sum[ACC_W] ^ sum[ACC_W-1];
  assign sat      = acc_en & ~start & ovf;

  always_ff @(posedge Clk) begin
    if (Reset)
      acc <= '0;
    else if (acc_en) begin
      if (start)
        acc <= prod_ext;
      else if (ovf)
        acc <= sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc <= sum[ACC_W-1:0];
    end
  end
endmodule

module neuron_accumulator_bank #(
  parameter int N_NEURONS = 20,
  parameter int N_OUT     = 10,
  parameter int DATA_W    = 16,
  parameter int FRAC_W    = 8,
  parameter int ACC_W     = 40
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [2:0]                    Layer,
  input  logic [2:0]                    Active,
  input  logic                          ActFuncActive,
  input  logic [DATA_W-1:0]             x_in,
  input  logic [N_NEURONS*DATA_W-1:0]   w_in,
  output logic                          act_valid,
  output logic [4:0]                    act_idx,
  output logic [DATA_W-1:0]             act_data,
  output logic                          layer_done,
  output logic                          acc_ovf
);
  logic [N_NEURONS-1:0][ACC_W-1:0] acc_q;
  logic [N_NEURONS-1:0]            lane_sat;
  logic                            acc_en, acc_en_q, start;
  logic [4:0]                      ptr, cnt;
  logic [2:0]                      layer_q;
  logic [ACC_W-1:0]                acc_sel, relu, shifted;
  logic [DATA_W-1:0]               drain_data;

  assign acc_en = |Active;
  assign start  = acc_en & ~acc_en_q;

  neuron_acc_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane [N_NEURONS-1:0] (
    .Clk    (Clk),
    .Reset  (Reset),
    .acc_en (acc_en),
    .start  (start),
    .x      (x_in),
    .w      (w_in),
    .acc    (acc_q),
    .sat    (lane_sat)
  );

  always_comb begin
    cnt     = (layer_q == 3'b100) ? 5'(N_OUT) : 5'(N_NEURONS);
    acc_sel = (ptr < 5'(N_NEURONS)) ? acc_q[ptr] : '0;
    relu    = acc_sel[ACC_W-1] ? '0 : acc_sel;
    shifted = relu >> FRAC_W;
    // Anything at or above the sign position of DATA_W clamps to the positive max.
    drain_data = (|shifted[ACC_W-1:DATA_W-1]) ? {1'b0, {(DATA_W-1){1'b1}}}
                                              : {1'b0, shifted[DATA_W-2:0]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_en_q   <= 1'b0;
      ptr        <= '0;
      layer_q    <= 3'b001;
      act_valid  <= 1'b0;
      act_idx    <= '0;
      act_data   <= '0;
      layer_done <= 1'b0;
      acc_ovf    <= 1'b0;
    end else begin
      acc_en_q   <= acc_en;
      act_valid  <= 1'b0;
      layer_done <= 1'b0;
      if (acc_en) begin
        if (start) begin
          acc_ovf <= 1'b0;
          ptr     <= '0;
          layer_q <= Layer;
        end else if (|lane_sat)
          acc_ovf <= 1'b1;
      end else if (ActFuncActive && ptr < cnt) begin
        act_valid  <= 1'b1;
        act_idx    <= ptr;
        act_data   <= drain_data;
        layer_done <= (ptr == cnt - 5'd1);
        ptr        <= ptr + 5'd1;
      end
    end
  end
endmodule
